// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O bridge: I/O page offsets, STATUS bit
// positions and the UART serializer state encoding.
package cpu_io_pkg;

    localparam logic [3:0] OFF_UART_DATA = 4'h0;
    localparam logic [3:0] OFF_STATUS    = 4'h1;
    localparam logic [3:0] OFF_LED       = 4'h2;
    localparam logic [3:0] OFF_CYCLE_LO  = 4'h3;
    localparam logic [3:0] OFF_CYCLE_HI  = 4'h4;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_BUSY  = 2;
    localparam int unsigned ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/cpu_io_bridge_uart_tx.sv
// 8N1 serializer. Accepts a byte when ready (IDLE, or last STOP cycle so
// frames can run back-to-back) and drives a registered, idle-high line.
module uart_tx
    import cpu_io_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned    TW   = $clog2(BAUD_DIV);
    localparam logic [TW-1:0]  LAST = TW'(BAUD_DIV - 1);

    uart_state_t   state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tick;

    assign tick  = (timer == LAST);
    assign ready = (state == IDLE) || ((state == STOP) && tick);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (valid) begin
                        shift <= data;
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        timer <= '0;
                        if (valid) begin
                            shift <= data;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// Address decoder between the CPU memory port and block RAM; the top 4 KiB
// page maps a UART TX FIFO, LED register and 32-bit cycle counter.
module cpu_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_DIV   = 434,
    parameter logic [3:0]  IO_PAGE    = 4'hF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_raddr_i,
    input  logic        cpu_rd_i,
    output logic [15:0] cpu_rdata_o,
    input  logic [15:0] cpu_waddr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic        cpu_wr_i,
    output logic [15:0] ram_raddr_o,
    input  logic [15:0] ram_rdata_i,
    output logic [15:0] ram_waddr_o,
    output logic [15:0] ram_wdata_o,
    output logic        ram_wr_o,
    output logic        uart_tx_o,
    output logic [7:0]  led_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Asynchronous assertion, release synchronised to clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic       io_r, io_w;
    logic [3:0] roff, woff;

    assign io_r = (cpu_raddr_i[15:12] == IO_PAGE);
    assign io_w = (cpu_waddr_i[15:12] == IO_PAGE);
    assign roff = cpu_raddr_i[3:0];
    assign woff = cpu_waddr_i[3:0];

    assign ram_raddr_o = cpu_raddr_i;
    assign ram_waddr_o = cpu_waddr_i;
    assign ram_wdata_o = cpu_wdata_i;
    assign ram_wr_o    = cpu_wr_i & ~io_w;

    logic          push_req, push, pop, full, empty, ready, busy;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_req = cpu_wr_i & io_w & (woff == OFF_UART_DATA);
    assign push     = push_req & ~full;
    assign pop      = ready & ~empty;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= cpu_wdata_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    logic        ovf;
    logic [31:0] cycle;
    logic [15:0] hi_shadow;
    logic        rd_io_q;
    logic [15:0] io_rdata_q;
    logic [15:0] status;
    logic [15:0] io_rdata;

    assign status = {8'(count), 4'b0000, ovf, busy, full, empty};

    always_comb begin
        io_rdata = '0;
        case (roff)
            OFF_STATUS:   io_rdata = status;
            OFF_LED:      io_rdata = {8'h00, led_o};
            OFF_CYCLE_LO: io_rdata = cycle[15:0];
            OFF_CYCLE_HI: io_rdata = hi_shadow;
            default:      io_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf        <= 1'b0;
            led_o      <= '0;
            cycle      <= '0;
            hi_shadow  <= '0;
            rd_io_q    <= 1'b1;
            io_rdata_q <= '0;
        end else begin
            // An overflowing push in the same cycle as a clear keeps OVF set.
            if (push_req && full)
                ovf <= 1'b1;
            else if (cpu_wr_i && io_w && woff == OFF_STATUS && cpu_wdata_i[ST_OVF])
                ovf <= 1'b0;

            if (cpu_wr_i && io_w && woff == OFF_LED)
                led_o <= cpu_wdata_i[7:0];

            if (cpu_wr_i && io_w && woff == OFF_CYCLE_LO)
                cycle <= '0;
            else
                cycle <= cycle + 32'd1;

            if (cpu_rd_i && io_r && roff == OFF_CYCLE_LO)
                hi_shadow <= cycle[31:16];

            rd_io_q    <= cpu_rd_i & io_r;
            io_rdata_q <= io_rdata;
        end
    end

    assign cpu_rdata_o = rd_io_q ? io_rdata_q : ram_rdata_i;

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (mem[rptr]),
        .valid (~empty),
        .ready (ready),
        .tx    (uart_tx_o),
        .busy  (busy)
    );

endmodule

// File: doc/cpu_io_bridge.md
Name: cpu_io_bridge

Overview:
- Sits directly downstream of the CPU memory port, between the CPU and the block RAM.
- Decodes every CPU read and write. Addresses 0x0000–0xEFFF pass through to RAM. Addresses 0xF000–0xFFFF hit a small I/O register file.
- The I/O file holds a UART transmit FIFO with an 8N1 serializer, an LED register and a 32-bit cycle counter.
- Keeps the CPU's fixed one-cycle read latency. The CPU has no stall input, so the bridge never inserts wait states.

Parameters:
- FIFO_DEPTH, 16, UART TX FIFO entries; power of two, minimum 2.
- BAUD_DIV, 434, clk cycles per UART bit; minimum 2.
- IO_PAGE, 4'hF, value of addr[15:12] that selects the I/O page.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- cpu_raddr_i  in  16  CPU read address.
- cpu_rd_i  in  1  CPU read strobe.
- cpu_rdata_o  out  16  read data, valid the cycle after raddr/rd.
- cpu_waddr_i  in  16  CPU write address.
- cpu_wdata_i  in  16  CPU write data.
- cpu_wr_i  in  1  CPU write strobe.
- ram_raddr_o  out  16  RAM read address (combinational passthrough).
- ram_rdata_i  in  16  RAM read data, one cycle latency.
- ram_waddr_o  out  16  RAM write address.
- ram_wdata_o  out  16  RAM write data.
- ram_wr_o  out  1  RAM write enable; asserted only for non-I/O addresses.
- uart_tx_o  out  1  serial output; idles high.
- led_o  out  8  LED register.

Behaviour:
- Address decode:
  - An access is I/O when addr[15:12]==IO_PAGE; only addr[3:0] is decoded inside the page.
  - Read and write paths decode independently. A read and a write in the same cycle are both serviced.
- Write path:
  - ram_waddr_o, ram_wdata_o and ram_raddr_o are combinational copies of the CPU inputs.
  - ram_wr_o = cpu_wr_i & ~io_w.
- Read path:
  - Registered rd_io_q = cpu_rd_i & io_r, and registered io_rdata_q.
  - cpu_rdata_o = rd_io_q ? io_rdata_q : ram_rdata_i.
  - Read latency is exactly 1 cycle for both RAM and I/O.
- Register map (offsets):
  - 0x0 UART_DATA
    - Write: push wdata[7:0] to the FIFO.
    - If the FIFO is full at the time of the write, the byte is dropped and OVF is set. This holds even if a pop happens in the same cycle.
    - Read: 0.
  - 0x1 STATUS
    - Read: bit0 EMPTY, bit1 FULL, bit2 BUSY (serializer not IDLE), bit3 OVF (sticky), bits[15:8] FIFO count, other bits 0.
    - Write with wdata[3]=1 clears OVF. If an overflowing push happens in the same cycle, the set wins.
  - 0x2 LED
    - R/W, bits[7:0]; led_o updates on the cycle after the write.
  - 0x3 CYCLE_LO
    - Read: counter[15:0]. The same read latches counter[31:16] into hi_shadow.
    - Write (any value): counter becomes 0 on the next cycle.
  - 0x4 CYCLE_HI
    - Read: hi_shadow. Write ignored.
  - All other offsets: read 0, write ignored.
- Cycle counter:
  - 32-bit, free-running, +1 per clk, wraps at 2^32.
  - Reading CYCLE_LO then CYCLE_HI gives a coherent 32-bit value.
- FIFO:
  - Circular buffer with read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - count_next = count + push − pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop only occurs when count≠0.
- Serializer state machine, with bit timer 0..BAUD_DIV−1:
  - IDLE (tx=1): if the FIFO is non-empty, pop into the shift register and go to START.
  - START (tx=0) for BAUD_DIV cycles, then DATA.
  - DATA: tx = shift[0], LSB first, 8 bits of BAUD_DIV cycles each, then STOP.
  - STOP (tx=1) for BAUD_DIV cycles. Then, if the FIFO is non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
  - Frame = 10×BAUD_DIV cycles.
  - uart_tx_o is registered.
- Reset (asynchronous assertion, any time including mid-frame):
  - State IDLE, uart_tx_o=1, FIFO empty, OVF=0, led_o=0, counter=0, hi_shadow=0.
  - rd_io_q=1 and io_rdata_q=0, so cpu_rdata_o=0 while in reset.
  - Deassertion is synchronous to clk; this is handled at the top level.

Decomposition:
- Package cpu_io_pkg holds:
  - IO offset constants (UART_DATA, STATUS, LED, CYCLE_LO, CYCLE_HI).
  - STATUS bit positions.
  - The uart_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_tx:
  - Contains the serializer and bit timer.
  - Input: byte with valid/ready; ready is high in IDLE and in the last cycle of STOP.
  - Outputs: tx, busy.
- Bridge top: decode, FIFO, registers, counter and read mux. Pop = ready & ~empty.

Test Plan:
- Reset mid-frame: assert reset_n=0 during DATA → uart_tx_o=1 and led_o=0 immediately. After release, a STATUS read returns 0x0001.
- RAM passthrough: write 0x1234 to 0x0010 → ram_wr_o=1, ram_waddr_o=0x0010. Read 0x0010 with ram_rdata_i=0xBEEF → cpu_rdata_o=0xBEEF next cycle. Write to 0xF002 → ram_wr_o=0.
- UART frame, BAUD_DIV=4: write 0x55 to 0xF000 → tx low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4. BUSY=1 throughout the 40 cycles.
- Overflow, FIFO_DEPTH=4, tx idle: write 6 bytes on consecutive cycles → byte0 popped, bytes1–4 queued, byte5 dropped. STATUS reads 0x040E. Writing 0x0008 to STATUS → STATUS reads 0x0406. All 5 bytes appear back-to-back with no idle gap.
- Cycle counter: write 0xF003, wait 65541 cycles, read 0xF003 then 0xF004 → HI=0x0001. LO equals the elapsed cycles mod 2^16, checked against the bench's model.
- LED and unmapped: write 0x12A5 to 0xF002 → led_o=0xA5; reading 0xF002 returns 0x00A5; reading 0xF00F returns 0x0000.
